mem_arbiter: RTL and testbench

- Shares the single-port `memory` block between NUM_REQ bus masters, e.g. the `processor` plus a debug/boot loader.
- Round-robin grant with a registered memory-side interface.
- Sits between the masters and `memory` in the top level; drives memory addr/we/data and returns read data plus a per-requester ack.

---
 rtl/mem_arb_pkg.sv | 39 +++
 rtl/mem_arbiter_rr.sv | 16 +
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, lock limit
// and the round-robin pick helper used by rr_arbiter.
package mem_arb_pkg;

    // Widest requester vector the helper supports (NUM_REQ is 2..8).
    localparam int MAX_REQ = 8;

    // Longest run of back-to-back locked transactions before the lock is broken.
    localparam int LOCK_MAX = 16;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE   = 2'd0;
    localparam arb_state_t ACCESS = 2'd1;
    localparam arb_state_t DONE   = 2'd2;

    // First set bit of req scanning upward from ptr with wrap-around over n
    // requesters; returns a one-hot vector, or zero when nothing is requested.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] gnt;
        int                 idx;
        gnt = '0;
        // Scan from the far end back towards ptr so the closest hit wins.
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (i < n) begin
                idx = (int'(ptr) + i) % n;
                if (req[idx]) begin
                    gnt = MAX_REQ'(1) << idx;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Combinational round-robin picker: one-hot grant from a request vector and
// a priority pointer. Purely combinational so it can be reused elsewhere.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [2:0]         i_ptr,
    output logic [NUM_REQ-1:0] o_gnt
);

    // Zero-extend to the helper width and trim the answer back to NUM_REQ.
    assign o_gnt = NUM_REQ'(rr_pick(MAX_REQ'(i_req), i_ptr, NUM_REQ));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_REQ masters.
// FSM IDLE -> ACCESS -> DONE with registered memory-side address/strobe/data.
// Optional build macro MEM_ARB_LOCK_EN adds lock_i for atomic back-to-back
// sequences by one master (broken after LOCK_MAX transactions).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      reset_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic [DATA_W-1:0]         rdata_o,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic                      busy_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic                      mem_we_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    input  logic [DATA_W-1:0]         mem_rdata_i
`ifdef MEM_ARB_LOCK_EN
    ,
    input  logic [NUM_REQ-1:0]        lock_i
`endif
);

    arb_state_t          r_state;
    logic [2:0]          r_ptr;
    logic [2:0]          r_win_idx;
    logic [2:0]          r_cnt;
    logic                r_we;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_ack;
    logic [DATA_W-1:0]   r_rdata;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_we;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic [NUM_REQ-1:0]  w_pick;
    logic [NUM_REQ-1:0]  w_sel;
    logic [2:0]          w_win_idx;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [DATA_W-1:0]   w_win_wdata;
    logic                w_win_we;
    logic [2:0]          w_ptr_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .i_req (req_i),
        .i_ptr (r_ptr),
        .o_gnt (w_pick)
    );

`ifdef MEM_ARB_LOCK_EN
    logic                r_forced;
    logic [4:0]          r_lock_cnt;
    logic [NUM_REQ-1:0]  w_owner_oh;

    // While a lock is being honoured only the previous owner may win.
    assign w_owner_oh = NUM_REQ'(1) << r_win_idx;
    assign w_sel      = r_forced ? (w_owner_oh & req_i) : w_pick;
`else
    assign w_sel = w_pick;
`endif

    // Mux out the winner's index and request fields from the packed buses.
    always_comb begin
        w_win_idx   = '0;
        w_win_addr  = '0;
        w_win_wdata = '0;
        w_win_we    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_sel[k]) begin
                w_win_idx   = 3'(k);
                w_win_addr  = addr_i[k*ADDR_W +: ADDR_W];
                w_win_wdata = wdata_i[k*DATA_W +: DATA_W];
                w_win_we    = we_i[k];
            end
        end
    end

    assign w_ptr_next = (r_win_idx == 3'(NUM_REQ - 1)) ? 3'd0 : r_win_idx + 3'd1;

    // Transaction FSM; async reset aborts any access and drops the write strobe.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_win_idx   <= '0;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_gnt       <= '0;
            r_ack       <= '0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
`ifdef MEM_ARB_LOCK_EN
            r_forced    <= 1'b0;
            r_lock_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_sel) begin
                        r_gnt       <= w_sel;
                        r_win_idx   <= w_win_idx;
                        r_we        <= w_win_we;
                        r_mem_addr  <= w_win_addr;
                        r_mem_wdata <= w_win_wdata;
                        r_mem_we    <= w_win_we;
                        r_cnt       <= w_win_we ? 3'd1 : 3'(READ_LATENCY);
                        r_state     <= ACCESS;
                    end
`ifdef MEM_ARB_LOCK_EN
                    else if (r_forced) begin
                        // Locked owner went away: fall back to normal arbitration.
                        r_forced   <= 1'b0;
                        r_lock_cnt <= '0;
                        r_ptr      <= w_ptr_next;
                    end
`endif
                end
                ACCESS: begin
                    // Memory commits a write on the first ACCESS edge only.
                    r_mem_we <= 1'b0;
                    if (r_cnt == 3'd1) begin
                        if (!r_we) begin
                            r_rdata <= mem_rdata_i;
                        end
                        r_ack   <= r_gnt;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                DONE: begin
                    r_ack   <= '0;
                    r_gnt   <= '0;
                    r_state <= IDLE;
`ifdef MEM_ARB_LOCK_EN
                    if (((lock_i & w_owner_oh) != '0) && (r_lock_cnt < 5'(LOCK_MAX - 1))) begin
                        r_forced   <= 1'b1;
                        r_lock_cnt <= r_lock_cnt + 5'd1;
                    end else begin
                        r_forced   <= 1'b0;
                        r_lock_cnt <= '0;
                        r_ptr      <= w_ptr_next;
                    end
`else
                    r_ptr <= w_ptr_next;
`endif
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ack_o       = r_ack;
    assign rdata_o     = r_rdata;
    assign gnt_o       = r_gnt;
    assign busy_o      = (r_state == ACCESS) || (r_state == DONE);
    assign mem_addr_o  = r_mem_addr;
    assign mem_we_o    = r_mem_we;
    assign mem_wdata_o = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: random masters, a 16-word memory model,
// and a transaction-level reference (round-robin order, fixed latencies,
// memory contents) feeding an expected queue checked by a monitor.
module tb_mem_arbiter;

  localparam int NR = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RL = 3;

  logic              clk = 1'b0;
  logic              reset_i;
  logic [NR-1:0]     req_i;
  logic [NR-1:0]     we_i;
  logic [NR*AW-1:0]  addr_i;
  logic [NR*DW-1:0]  wdata_i;
  logic [NR-1:0]     ack_o;
  logic [DW-1:0]     rdata_o;
  logic [NR-1:0]     gnt_o;
  logic              busy_o;
  logic [AW-1:0]     mem_addr_o;
  logic              mem_we_o;
  logic [DW-1:0]     mem_wdata_o;
  logic [DW-1:0]     mem_rdata_i;
`ifdef MEM_ARB_LOCK_EN
  logic [NR-1:0]     lock_i = '0;
`endif

  mem_arbiter #(
    .NUM_REQ      (NR),
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .READ_LATENCY (RL)
  ) dut (
    .clk         (clk),
    .reset_i     (reset_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .ack_o       (ack_o),
    .rdata_o     (rdata_o),
    .gnt_o       (gnt_o),
    .busy_o      (busy_o),
    .mem_addr_o  (mem_addr_o),
    .mem_we_o    (mem_we_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
`ifdef MEM_ARB_LOCK_EN
    , .lock_i    (lock_i)
`endif
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory environment ----------------
  logic [DW-1:0] tb_mem [16];

  function automatic logic [DW-1:0] init_val(input int i);
    return 32'hDEADBEEF ^ DW'(i);
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) tb_mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (mem_we_o) tb_mem[mem_addr_o[3:0]] = mem_wdata_o;
    end
  end

  assign mem_rdata_i = tb_mem[mem_addr_o[3:0]];

  // ---------------- scoreboard state ----------------
  typedef struct {
    int            m;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            start;
    int            ack;
  } txn_t;

  txn_t          exp_q[$];
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] last_rd;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference-model / driver state ----------------
  logic          pend [NR];
  logic          pwe  [NR];
  logic [AW-1:0] pa   [NR];
  logic [DW-1:0] pwd  [NR];
  int            model_free = 0;
  int            model_ptr  = 0;
  int            infl       = -1;
  int            infl_end   = 0;
  int            rnd_pct    = 0;

  task automatic new_txn(input int k);
    pend[k] = 1'b1;
    pwe[k]  = 1'($urandom_range(1));
    pa[k]   = ($urandom_range(9) == 0) ? AW'($urandom) : AW'($urandom_range(15));
    pwd[k]  = DW'($urandom);
  endtask

  // One driver cycle: new requests, drive inputs, and if the arbiter is free
  // this cycle decide (by round-robin rule) which master is served next.
  task automatic step();
    int w;
    @(posedge clk);
    #1;
    if (infl >= 0 && cyc > infl_end) infl = -1;
    for (int k = 0; k < NR; k++) begin
      if (!pend[k] && k != infl && $urandom_range(99) < rnd_pct) new_txn(k);
    end
    for (int k = 0; k < NR; k++) begin
      if (k == infl) begin
        // In-flight master scribbles on its inputs; they must be ignored.
        req_i[k]              = 1'($urandom_range(1));
        we_i[k]               = 1'($urandom_range(1));
        addr_i[k*AW +: AW]    = AW'($urandom);
        wdata_i[k*DW +: DW]   = DW'($urandom);
      end else if (pend[k]) begin
        req_i[k]              = 1'b1;
        we_i[k]               = pwe[k];
        addr_i[k*AW +: AW]    = pa[k];
        wdata_i[k*DW +: DW]   = pwd[k];
      end else begin
        req_i[k]              = 1'b0;
        we_i[k]               = 1'($urandom_range(1));
        addr_i[k*AW +: AW]    = AW'($urandom);
        wdata_i[k*DW +: DW]   = DW'($urandom);
      end
    end
    if (cyc >= model_free) begin
      w = -1;
      for (int i = NR - 1; i >= 0; i--) begin
        if (pend[(model_ptr + i) % NR]) w = (model_ptr + i) % NR;
      end
      if (w >= 0) begin
        txn_t t;
        t.m     = w;
        t.we    = pwe[w];
        t.addr  = pa[w];
        t.wdata = pwd[w];
        t.start = cyc + 1;
        t.ack   = cyc + 1 + (pwe[w] ? 1 : RL);
        exp_q.push_back(t);
        model_free = t.ack + 1;
        infl       = w;
        infl_end   = t.ack;
        pend[w]    = 1'b0;
        model_ptr  = (w + 1) % NR;
      end
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    txn_t        h;
    logic        in_busy;
    logic [NR-1:0] oh;
    forever begin
      @(negedge clk);
      if (reset_i) begin
        check("rst_ack",   ack_o,      0);
        check("rst_gnt",   gnt_o,      0);
        check("rst_busy",  busy_o,     0);
        check("rst_we",    mem_we_o,   0);
        check("rst_addr",  mem_addr_o, 0);
        check("rst_wdata", mem_wdata_o,0);
        check("rst_rdata", rdata_o,    0);
      end else begin
        in_busy = 1'b0;
        oh      = '0;
        if (exp_q.size() > 0) begin
          h = exp_q[0];
          if (cyc >= h.start && cyc <= h.ack) begin
            in_busy = 1'b1;
            oh      = NR'(1) << h.m;
          end
        end
        check("busy", busy_o, in_busy);
        check("gnt",  gnt_o,  oh);
        check("mem_we", mem_we_o, in_busy && h.we && (cyc == h.start));
        if (in_busy) begin
          check("mem_addr", mem_addr_o, h.addr);
          if (h.we) check("mem_wdata", mem_wdata_o, h.wdata);
        end
        if (in_busy && cyc == h.ack) begin
          check("ack", ack_o, oh);
          if (h.we) ref_mem[h.addr[3:0]] = h.wdata;
          else      last_rd = ref_mem[h.addr[3:0]];
          void'(exp_q.pop_front());
        end else begin
          check("ack_idle", ack_o, 0);
        end
        check("rdata", rdata_o, last_rd);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    reset_i = 1'b1;
    req_i   = '0;
    we_i    = '0;
    addr_i  = '0;
    wdata_i = '0;
    last_rd = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    for (int k = 0; k < NR; k++) begin
      pend[k] = 1'b0; pwe[k] = 1'b0; pa[k] = '0; pwd[k] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    reset_i    = 1'b0;
    model_free = cyc;

    // Directed: simultaneous write (m0) and read (m1); m0 wins from reset.
    pend[0] = 1'b1; pwe[0] = 1'b1; pa[0] = 32'h10; pwd[0] = 32'hA5;
    pend[1] = 1'b1; pwe[1] = 1'b0; pa[1] = 32'h3;  pwd[1] = '0;
    rnd_pct = 0;
    repeat (15) step();

    // Directed: reset in the ACCESS cycle of a write.
    pend[0] = 1'b1; pwe[0] = 1'b1; pa[0] = 32'h5; pwd[0] = 32'h12345678;
    guard = 0;
    while (exp_q.size() == 0 && guard < 20) begin
      step();
      guard++;
    end
    @(posedge clk);
    #2;
    check("we_before_rst", mem_we_o, 1);
    reset_i = 1'b1;
    #1;
    check("we_async_drop",   mem_we_o, 0);
    check("busy_async_drop", busy_o,   0);
    check("gnt_async_drop",  gnt_o,    0);
    exp_q.delete();
    for (int k = 0; k < NR; k++) pend[k] = 1'b0;
    model_ptr = 0;
    infl      = -1;
    last_rd   = '0;
    req_i     = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_i    = 1'b0;
    model_free = cyc;

    // Everyone requests right after reset: requester 0 must be granted first.
    for (int k = 0; k < NR; k++) new_txn(k);
    rnd_pct = 60;
    repeat (3000) step();
    rnd_pct = 100;
    repeat (600) step();
    rnd_pct = 0;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
